// File: rtl/flash_sdram_responder.sv
// Arbitrates buffered flash program writes and CPU slot accesses onto one req/ack SDRAM port.
// CPU wins by default; a starvation counter forces a pending flash write through eventually.
module flash_sdram_responder #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [26:0] FLASH_LIMIT  = 27'h800000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [26:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_rnw,
  output logic [7:0]  cpu_dout,
  output logic        cpu_busy,
  input  logic [26:0] flash_addr,
  input  logic [7:0]  flash_din,
  input  logic        flash_req,
  output logic        flash_ready,
  output logic        flash_done,
  output logic [26:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, CPU, FLASH, DROP, DONE} state_t;

  state_t      state, next_state;
  logic        cpu_ce_q;
  logic        cpu_pend;
  logic [26:0] cpu_addr_q;
  logic [7:0]  cpu_din_q;
  logic        cpu_rnw_q;
  logic        fl_pend;
  logic [26:0] fl_addr_q;
  logic [7:0]  fl_din_q;
  logic [3:0]  starve;

  logic        cpu_cap, fl_cap;
  logic        eff_cpu, eff_fl;
  logic [26:0] eff_fl_addr;
  logic        acked, starved;

  assign cpu_cap     = cpu_ce & ~cpu_ce_q & ~cpu_pend;
  assign fl_cap      = flash_req & ~fl_pend;
  assign acked       = mem_req & mem_ack;
  assign starved     = (starve >= LIMIT);
  assign cpu_busy    = cpu_pend;
  assign flash_ready = ~fl_pend;

  // The IDLE decision looks through the capture registers so a request can be granted the cycle it arrives
  assign eff_cpu     = cpu_pend | cpu_cap;
  assign eff_fl      = fl_pend | fl_cap;
  assign eff_fl_addr = fl_pend ? fl_addr_q : flash_addr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    flash_done = 1'b0;
    case (state)
      IDLE: begin
        if (eff_cpu && !(starved && eff_fl)) next_state = CPU;
        else if (eff_fl)                     next_state = (eff_fl_addr < FLASH_LIMIT) ? FLASH : DROP;
      end
      CPU:   if (acked) next_state = IDLE;
      FLASH: if (acked) next_state = DONE;
      DROP:  next_state = DONE;
      DONE: begin
        flash_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Buffers and the memory port; the port is loaded on the first cycle of a grant and held until ack
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_ce_q   <= 1'b0;
      cpu_pend   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      cpu_rnw_q  <= 1'b0;
      fl_pend    <= 1'b0;
      fl_addr_q  <= '0;
      fl_din_q   <= '0;
      starve     <= '0;
      cpu_dout   <= 8'hFF;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      cpu_ce_q <= cpu_ce;
      if (cpu_cap) begin
        cpu_pend   <= 1'b1;
        cpu_addr_q <= cpu_addr;
        cpu_din_q  <= cpu_din;
        cpu_rnw_q  <= cpu_rnw;
      end
      if (fl_cap) begin
        fl_pend   <= 1'b1;
        fl_addr_q <= flash_addr;
        fl_din_q  <= flash_din;
      end
      case (state)
        CPU: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= cpu_addr_q;
            mem_din  <= cpu_din_q;
            mem_we   <= ~cpu_rnw_q;
          end else if (mem_ack) begin
            mem_req  <= 1'b0;
            cpu_pend <= 1'b0;
            if (cpu_rnw_q)             cpu_dout <= mem_dout;
            if (fl_pend && !starved)   starve   <= starve + 4'd1;
          end
        end
        FLASH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= fl_addr_q;
            mem_din  <= fl_din_q;
            mem_we   <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            fl_pend <= 1'b0;
            starve  <= '0;
          end
        end
        DROP:    fl_pend <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sdram_responder.sv
// Directed scenarios plus a randomized traffic phase checked against a simple memory model.
// The SDRAM side is an associative-array memory answering requests after a chosen delay.
module tb_flash_sdram_responder;

  localparam int unsigned STARVE_LIMIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce, cpu_rnw, flash_req;
  logic [26:0] cpu_addr, flash_addr;
  logic [7:0]  cpu_din, flash_din;
  logic [7:0]  cpu_dout;
  logic        cpu_busy, flash_ready, flash_done;
  logic [26:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_we, mem_req, mem_ack;
  logic        resp_ack = 1'b0;
  logic        late_ack = 1'b0;

  typedef struct packed { logic [26:0] addr; logic [7:0] data; } wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_count = 0;
  int          ack_delay  = 3;
  bit          rand_delay = 1'b0;
  bit          resp_en    = 1'b1;
  wr_t         wr_q[$];
  logic [7:0]  sdram [logic [26:0]];
  logic [7:0]  ref_mem [logic [26:0]];

  int          w0, d0, cpu_grants, cpu_left, fl_left, exp_done;
  bit          seen_flash, busy_at_flash, prev_req, prev_busy, ce_prev, pend_rd, finished, drop_seen;
  logic [7:0]  pend_val, q, d;
  logic [26:0] a, drop_addr;

  assign mem_ack = resp_ack | late_ack;

  always #5 clk = ~clk;

  flash_sdram_responder #(.STARVE_LIMIT(STARVE_LIMIT), .FLASH_LIMIT(27'h800000)) dut (
    .clk(clk), .reset(reset),
    .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_rnw(cpu_rnw),
    .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
    .flash_addr(flash_addr), .flash_din(flash_din), .flash_req(flash_req),
    .flash_ready(flash_ready), .flash_done(flash_done),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_dout(mem_dout)
  );

  always @(posedge clk) if (flash_done === 1'b1) done_count++;

  // SDRAM model: acks a held request after ack_delay (or a random delay) cycles
  initial begin
    int age, dly;
    age = 0;
    dly = 0;
    mem_dout = 8'h00;
    sdram[27'h000020] = 8'hC3;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (resp_en && mem_req === 1'b1) begin
        if (age == dly) begin
          resp_ack = 1'b1;
          if (mem_we) begin
            sdram[mem_addr] = mem_din;
            wr_q.push_back('{addr: mem_addr, data: mem_din});
          end else begin
            mem_dout = sdram.exists(mem_addr) ? sdram[mem_addr] : 8'h00;
          end
        end
        age++;
      end else begin
        age = 0;
        dly = rand_delay ? int'($urandom_range(0, 4)) : ack_delay;
      end
    end
  end

  function automatic logic [7:0] ref_rd(input logic [26:0] addr);
    return ref_mem.exists(addr) ? ref_mem[addr] : 8'h00;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy_low(input string tag);
    int k = 0;
    while (cpu_busy !== 1'b0 && k < 60) begin step(1); k++; end
    check_output(tag, 32'(k < 60), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (flash_done !== 1'b1 && k < 60) begin step(1); k++; end
    check_output(tag, 32'(k < 60), 32'd1);
  endtask

  task automatic cpu_access(input logic [26:0] addr, input logic rnw, input logic [7:0] din,
                            output logic [7:0] dout);
    cpu_addr = addr;
    cpu_rnw  = rnw;
    cpu_din  = din;
    cpu_ce   = 1'b1;
    step(1);
    cpu_ce = 1'b0;
    wait_busy_low("cpu_access_timeout");
    dout = cpu_dout;
  endtask

  initial begin
    reset = 1'b1;
    cpu_ce = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_din = '0;
    flash_req = 1'b0; flash_addr = '0; flash_din = '0;
    step(3);
    check_output("rst_cpu_dout", cpu_dout, 8'hFF);
    check_output("rst_cpu_busy", cpu_busy, 0);
    check_output("rst_flash_ready", flash_ready, 1);
    check_output("rst_flash_done", flash_done, 0);
    check_output("rst_mem_req", mem_req, 0);
    check_output("rst_mem_we", mem_we, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_mem_din", mem_din, 0);
    reset = 1'b0;
    step(1);

    // Flash write only, ack three cycles after the request
    flash_addr = 27'h000100; flash_din = 8'h5A; flash_req = 1'b1;
    step(1);
    flash_req = 1'b0;
    check_output("t1_ready_low", flash_ready, 0);
    check_output("t1_req_n1", mem_req, 0);
    step(1);
    check_output("t1_req_n2", mem_req, 1);
    check_output("t1_addr", mem_addr, 27'h000100);
    check_output("t1_din", mem_din, 8'h5A);
    check_output("t1_we", mem_we, 1);
    step(3);
    check_output("t1_req_held", mem_req, 1);
    check_output("t1_done_early", flash_done, 0);
    step(1);
    check_output("t1_done", flash_done, 1);
    check_output("t1_ready_back", flash_ready, 1);
    check_output("t1_req_drop", mem_req, 0);
    step(1);
    check_output("t1_done_one_cycle", flash_done, 0);
    check_output("t1_done_count", done_count, 1);
    check_output("t1_wr_count", wr_q.size(), 1);
    check_output("t1_wr_entry", {wr_q[0].addr, wr_q[0].data}, {27'h000100, 8'h5A});

    // CPU read and flash request in the same cycle: CPU first
    w0 = wr_q.size(); d0 = done_count;
    cpu_addr = 27'h000020; cpu_rnw = 1'b1; cpu_ce = 1'b1;
    flash_addr = 27'h000200; flash_din = 8'h77; flash_req = 1'b1;
    step(1);
    cpu_ce = 1'b0; flash_req = 1'b0;
    check_output("t2_busy", cpu_busy, 1);
    check_output("t2_ready_low", flash_ready, 0);
    step(1);
    check_output("t2_req_n2", mem_req, 1);
    check_output("t2_cpu_first", mem_we, 0);
    check_output("t2_cpu_addr", mem_addr, 27'h000020);
    wait_busy_low("t2_busy_timeout");
    check_output("t2_cpu_dout", cpu_dout, 8'hC3);
    wait_done("t2_done_timeout");
    step(1);
    check_output("t2_wr_count", wr_q.size(), w0 + 1);
    check_output("t2_wr_entry", {wr_q[wr_q.size()-1].addr, wr_q[wr_q.size()-1].data}, {27'h000200, 8'h77});
    step(5);
    check_output("t2_done_count", done_count, d0 + 1);

    // Starvation: back-to-back CPU reads with a flash write pending
    w0 = wr_q.size(); d0 = done_count;
    ack_delay = 1;
    cpu_grants = 0; seen_flash = 1'b0; busy_at_flash = 1'b0; prev_req = 1'b0;
    cpu_addr = 27'h000040; cpu_rnw = 1'b1; cpu_ce = 1'b1;
    flash_addr = 27'h000240; flash_din = 8'h3C; flash_req = 1'b1;
    for (int i = 0; i < 100 && !seen_flash; i++) begin
      step(1);
      flash_req = 1'b0;
      if (mem_req === 1'b1 && !prev_req) begin
        if (mem_we === 1'b1) begin
          seen_flash = 1'b1;
          busy_at_flash = cpu_busy;
        end else cpu_grants++;
      end
      prev_req = mem_req;
      cpu_ce = !cpu_busy && !seen_flash;
    end
    cpu_ce = 1'b0;
    check_output("t3_flash_issued", seen_flash, 1);
    check_output("t3_cpu_grants", cpu_grants, STARVE_LIMIT);
    check_output("t3_cpu_pending", busy_at_flash, 1);
    wait_done("t3_done_timeout");
    wait_busy_low("t3_busy_timeout");
    step(2);
    check_output("t3_done_count", done_count, d0 + 1);
    check_output("t3_wr_entry", {wr_q[wr_q.size()-1].addr, wr_q[wr_q.size()-1].data}, {27'h000240, 8'h3C});
    ack_delay = 3;

    // Out-of-window flash write is dropped but still retired
    w0 = wr_q.size(); d0 = done_count;
    flash_addr = 27'h800000; flash_din = 8'hAB; flash_req = 1'b1;
    step(1);
    flash_req = 1'b0;
    check_output("t4_no_req", mem_req, 0);
    check_output("t4_ready_low", flash_ready, 0);
    check_output("t4_done_n1", flash_done, 0);
    step(1);
    check_output("t4_done_n2", flash_done, 1);
    check_output("t4_ready_back", flash_ready, 1);
    check_output("t4_no_req2", mem_req, 0);
    step(1);
    check_output("t4_done_one_cycle", flash_done, 0);
    check_output("t4_no_write", wr_q.size(), w0);
    check_output("t4_done_count", done_count, d0 + 1);

    // Second request while the buffer is full is ignored
    w0 = wr_q.size(); d0 = done_count;
    flash_addr = 27'h000300; flash_din = 8'h11; flash_req = 1'b1;
    step(1);
    check_output("t5_ready_low", flash_ready, 0);
    flash_addr = 27'h000304; flash_din = 8'h22;
    step(1);
    flash_req = 1'b0;
    wait_done("t5_done_timeout");
    step(8);
    check_output("t5_wr_count", wr_q.size(), w0 + 1);
    check_output("t5_wr_entry", {wr_q[wr_q.size()-1].addr, wr_q[wr_q.size()-1].data}, {27'h000300, 8'h11});
    check_output("t5_done_count", done_count, d0 + 1);
    check_output("t5_idle", mem_req, 0);

    // Reset while a flash write is on the bus; the late ack must be ignored
    w0 = wr_q.size(); d0 = done_count;
    resp_en = 1'b0;
    flash_addr = 27'h000400; flash_din = 8'h99; flash_req = 1'b1;
    step(1);
    flash_req = 1'b0;
    step(1);
    check_output("t6_req_high", mem_req, 1);
    step(2);
    reset = 1'b1;
    step(1);
    check_output("t6_req_dropped", mem_req, 0);
    check_output("t6_ready", flash_ready, 1);
    reset = 1'b0;
    late_ack = 1'b1;
    step(1);
    late_ack = 1'b0;
    resp_en = 1'b1;
    step(4);
    check_output("t6_no_done", done_count, d0);
    check_output("t6_no_write", wr_q.size(), w0);
    check_output("t6_mem_req", mem_req, 0);
    check_output("t6_cpu_dout", cpu_dout, 8'hFF);
    check_output("t6_cpu_busy", cpu_busy, 0);
    check_output("t6_mem_addr", mem_addr, 0);

    // Random traffic: CPU owns 0x1000.., flash writes 0x2000.. or out of window
    rand_delay = 1'b1;
    d0 = done_count; exp_done = 0;
    cpu_left = 30; fl_left = 12;
    pend_rd = 1'b0; pend_val = 8'h00; prev_busy = 1'b0; finished = 1'b0; drop_seen = 1'b0;
    drop_addr = 27'h800000;
    for (int i = 0; i < 3000 && !finished; i++) begin
      step(1);
      if (prev_busy && cpu_busy === 1'b0 && pend_rd) begin
        check_output("rand_cpu_read", cpu_dout, pend_val);
        pend_rd = 1'b0;
      end
      prev_busy = cpu_busy;
      ce_prev = cpu_ce;
      cpu_ce = 1'b0;
      flash_req = 1'b0;
      if (cpu_busy === 1'b0 && !ce_prev && cpu_left > 0 && $urandom_range(0, 2) == 0) begin
        a = 27'h001000 + 27'($urandom_range(0, 15));
        cpu_addr = a;
        cpu_rnw = 1'($urandom_range(0, 1));
        if (cpu_rnw) begin
          pend_rd = 1'b1;
          pend_val = ref_rd(a);
        end else begin
          d = 8'($urandom);
          cpu_din = d;
          ref_mem[a] = d;
        end
        cpu_ce = 1'b1;
        cpu_left--;
      end
      if (flash_ready === 1'b1 && fl_left > 0 && $urandom_range(0, 3) == 0) begin
        if (fl_left == 12 || $urandom_range(0, 3) == 0) begin
          a = 27'h800000 + 27'($urandom_range(0, 255));
          drop_addr = a;
          drop_seen = 1'b1;
        end else a = 27'h002000 + 27'($urandom_range(0, 15));
        d = 8'($urandom);
        flash_addr = a;
        flash_din = d;
        if (a < 27'h800000) ref_mem[a] = d;
        flash_req = 1'b1;
        exp_done++;
        fl_left--;
      end
      finished = (cpu_left == 0 && fl_left == 0 && !pend_rd && cpu_ce == 1'b0 && flash_req == 1'b0 &&
                  cpu_busy === 1'b0 && flash_ready === 1'b1 && mem_req === 1'b0);
    end
    cpu_ce = 1'b0;
    flash_req = 1'b0;
    check_output("rand_phase_timeout", finished, 1);
    step(3);
    check_output("rand_done_count", done_count - d0, exp_done);
    foreach (ref_mem[k]) begin
      cpu_access(k, 1'b1, 8'h00, q);
      check_output("rand_readback", q, ref_mem[k]);
    end
    if (drop_seen) begin
      cpu_access(drop_addr, 1'b1, 8'h00, q);
      check_output("rand_drop_not_written", q, ref_rd(drop_addr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
